// File: rtl/tv80_busrq_dma.sv
// Block-copy engine that borrows the tv80s memory bus through busrq_n/busak_n.
// Moore outputs decode the registered state, so reset and cen=0 act on them directly.
module tv80_busrq_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cen,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic              bus_own,
  output logic [ADDR_W-1:0] dma_a,
  output logic [DATA_W-1:0] dma_do,
  input  logic [DATA_W-1:0] dma_di,
  output logic              dma_mreq_n,
  output logic              dma_rd_n,
  output logic              dma_wr_n,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL, FIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_r, dst_r, a_hold;
  logic [LEN_W-1:0]  cnt_r;
  logic [DATA_W-1:0] data_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src_r  <= '0;
      dst_r  <= '0;
      a_hold <= '0;
      cnt_r  <= '0;
      data_r <= '0;
    end else if (cen) begin
      state  <= state_nx;
      a_hold <= dma_a;
      case (state)
        IDLE: if (start && len != '0) begin
          src_r <= src_addr;
          dst_r <= dst_addr;
          cnt_r <= len;
        end
        // memory presented dma_di on the negedge inside RD
        RD: data_r <= dma_di;
        WR: begin
          src_r <= src_r + ADDR_W'(1);
          dst_r <= dst_r + ADDR_W'(1);
          cnt_r <= cnt_r - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dma_do = data_r;

  always_comb begin
    state_nx   = state;
    busrq_n    = 1'b1;
    bus_own    = 1'b0;
    dma_a      = a_hold;
    dma_mreq_n = 1'b1;
    dma_rd_n   = 1'b1;
    dma_wr_n   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (len != '0) ? REQ : FIN;
      end
      REQ: begin
        busrq_n = 1'b0;
        if (!busak_n) state_nx = RD;
      end
      RD: begin
        busrq_n    = 1'b0;
        bus_own    = 1'b1;
        dma_a      = src_r;
        dma_mreq_n = 1'b0;
        dma_rd_n   = 1'b0;
        state_nx   = WR;
      end
      WR: begin
        busrq_n    = 1'b0;
        bus_own    = 1'b1;
        dma_a      = dst_r;
        dma_mreq_n = 1'b0;
        dma_wr_n   = 1'b0;
        state_nx   = (cnt_r == LEN_W'(1)) ? REL : RD;
      end
      REL: if (busak_n) state_nx = FIN;
      FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tv80_busrq_dma.sv
// Bench for tv80_busrq_dma: 64K memory model, CPU bus-ack model, write scoreboard.
module tb_tv80_busrq_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0;
  logic [7:0]  len = '0;
  logic        busrq_n, busak_n = 1'b1, bus_own;
  logic [15:0] dma_a;
  logic [7:0]  dma_do, dma_di = '0;
  logic        dma_mreq_n, dma_rd_n, dma_wr_n, busy, done;

  tv80_busrq_dma dut (
    .clk(clk), .reset(reset), .cen(cen), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busrq_n(busrq_n), .busak_n(busak_n), .bus_own(bus_own),
    .dma_a(dma_a), .dma_do(dma_do), .dma_di(dma_di),
    .dma_mreq_n(dma_mreq_n), .dma_rd_n(dma_rd_n), .dma_wr_n(dma_wr_n),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    int          ack;
    bit          cen_tg;
    int          exp_writes;
    bit          exp_rq;
  } vec_t;

  logic [7:0] mem     [0:65535];
  logic [7:0] exp_mem [0:65535];
  wr_t        sb[$];

  int n_checks = 0, n_fail = 0;
  int n_writes, n_done, ack_dly = 0, ack_cnt = 0;
  bit rq_seen, acc_seen, cen_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory and bus monitor: writes land and reads update on the negedge
  always @(negedge clk) begin
    if (!dma_mreq_n && !dma_wr_n) begin
      mem[dma_a] = dma_do;
      if (cen) begin
        n_writes++;
        if (sb.size() == 0) check("unexpected_write", {16'h0, dma_a}, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = sb.pop_front();
          check("write_addr", {16'h0, dma_a}, {16'h0, w.a});
          check("write_data", {24'h0, dma_do}, {24'h0, w.d});
        end
      end
    end
    if (!dma_mreq_n) begin
      acc_seen = 1'b1;
      check("strobe_without_ack", {31'h0, busak_n}, 32'h0);
    end
    if (!busrq_n) rq_seen = 1'b1;
    if (done && cen) n_done++;
    dma_di = mem[dma_a];
  end

  // CPU side: grants after ack_dly cycles, releases as soon as busrq_n rises
  always @(posedge clk) begin
    #1;
    if (reset || busrq_n) begin
      busak_n = 1'b1;
      ack_cnt = 0;
    end else if (ack_cnt >= ack_dly) busak_n = 1'b0;
    else ack_cnt++;
  end

  always @(posedge clk) begin
    #1;
    cen = cen_mode ? ~cen : 1'b1;
  end

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    for (int i = 0; i < int'(n); i++) begin
      wr_t w;
      w.a = d + 16'(i);
      w.d = exp_mem[s + 16'(i)];
      exp_mem[w.a] = w.d;
      sb.push_back(w);
    end
  endtask

  task automatic clear_counts();
    n_writes = 0; n_done = 0; rq_seen = 1'b0; acc_seen = 1'b0;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    int c;
    @(posedge clk); #2;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    c = 0;
    while (!(busy || done) && c < 50) begin @(posedge clk); #2; c++; end
    check("start_accepted", {31'h0, busy || done}, 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (n_done == 0 && c < budget) begin @(negedge clk); #1; c++; end
    check("done_within_budget", {31'h0, n_done != 0}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    int errs;
    ack_dly = v.ack; cen_mode = v.cen_tg;
    clear_counts();
    push_copy(v.src, v.dst, v.len);
    launch(v.src, v.dst, v.len);
    start = 1'b0;
    wait_done(3000);
    cen_mode = 1'b0;
    repeat (4) @(posedge clk); #2;
    errs = 0;
    for (int i = 0; i < int'(v.len) + 1; i++)
      if (mem[v.dst + 16'(i)] !== exp_mem[v.dst + 16'(i)]) errs++;
    check("done_count", n_done, 1);
    check("write_count", n_writes, v.exp_writes);
    check("busrq_seen", {31'h0, rq_seen}, {31'h0, v.exp_rq});
    check("mem_access_seen", {31'h0, acc_seen}, {31'h0, v.len != 0});
    check("scoreboard_empty", sb.size(), 0);
    check("mem_compare", errs, 0);
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] orig;
    int c;
    vecs[0] = '{16'h1000, 16'h2000, 8'd4,   0, 1'b0, 4,   1'b1};
    vecs[1] = '{16'h1000, 16'h3000, 8'd4,   5, 1'b1, 4,   1'b1};
    vecs[2] = '{16'hFFFE, 16'h0010, 8'd3,   0, 1'b0, 3,   1'b1};
    vecs[3] = '{16'h4000, 16'h5000, 8'd0,   0, 1'b0, 0,   1'b0};
    vecs[4] = '{16'h6000, 16'h6001, 8'd5,   2, 1'b0, 5,   1'b1};
    vecs[5] = '{16'h7000, 16'h8000, 8'd255, 1, 1'b0, 255, 1'b1};

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33; mem[16'h1003] = 8'h44;
    for (int i = 0; i < 4; i++) exp_mem[16'h1000 + 16'(i)] = mem[16'h1000 + 16'(i)];

    #23;
    check("rst_busrq_n", {31'h0, busrq_n}, 32'h1);
    check("rst_bus_own", {31'h0, bus_own}, 32'h0);
    check("rst_strobes", {29'h0, dma_mreq_n, dma_rd_n, dma_wr_n}, 32'h7);
    check("rst_dma_a", {16'h0, dma_a}, 32'h0);
    check("rst_dma_do", {24'h0, dma_do}, 32'h0);
    check("rst_busy_done", {30'h0, busy, done}, 32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("copy_2003", {24'h0, mem[16'h2003]}, 32'h44);
    check("copy_2000", {24'h0, mem[16'h2000]}, 32'h11);
    for (int i = 0; i < 4; i++)
      check("cen_run_same", {24'h0, mem[16'h3000 + 16'(i)]}, {24'h0, mem[16'h2000 + 16'(i)]});
    check("wrap_0012", {24'h0, mem[16'h0012]}, {24'h0, mem[16'h0000]});

    // zero-length: done in the cycle after start is taken, bus untouched
    clear_counts();
    @(posedge clk); #2;
    len = 8'd0; start = 1'b1;
    @(posedge clk); #2;
    check("len0_done", {31'h0, done}, 32'h1);
    check("len0_busrq_n", {31'h0, busrq_n}, 32'h1);
    start = 1'b0;
    @(posedge clk); #2;
    check("len0_done_clears", {30'h0, done, busy}, 32'h0);

    // start held high through a copy yields exactly one copy
    clear_counts();
    ack_dly = 1;
    push_copy(16'h1000, 16'hA000, 8'd3);
    launch(16'h1000, 16'hA000, 8'd3);
    c = 0;
    while (n_done == 0 && c < 200) begin @(negedge clk); #1; c++; end
    start = 1'b0;
    repeat (20) @(posedge clk); #2;
    check("held_start_done", n_done, 1);
    check("held_start_writes", n_writes, 3);
    check("held_start_idle", {31'h0, busy}, 32'h0);
    check("held_start_sb", sb.size(), 0);

    // reset during the second write of an 8-byte copy
    clear_counts();
    ack_dly = 0;
    orig = mem[16'h9002];
    push_copy(16'h1000, 16'h9000, 8'd8);
    launch(16'h1000, 16'h9000, 8'd8);
    start = 1'b0;
    c = 0;
    while (n_writes < 2 && c < 100) begin @(negedge clk); #1; c++; end
    check("mid_wr_state", {31'h0, dma_wr_n}, 32'h0);
    reset = 1'b1;
    #1;
    check("abort_busrq_n", {31'h0, busrq_n}, 32'h1);
    check("abort_bus_own", {31'h0, bus_own}, 32'h0);
    check("abort_mreq_n", {31'h0, dma_mreq_n}, 32'h1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) @(posedge clk); #2;
    check("abort_writes", n_writes, 2);
    check("abort_no_done", n_done, 0);
    check("abort_byte2_kept", {24'h0, mem[16'h9002]}, {24'h0, orig});
    check("abort_byte1", {24'h0, mem[16'h9001]}, 32'h22);
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
